fpnew_divsqrt_issue_queue: RTL and testbench
============================================

Name: fpnew_divsqrt_issue_queue

Overview:
- Small in-order request FIFO directly upstream of the multi-cycle div/sqrt unit.
- Absorbs back-to-back DIV/SQRT issues from the operation-group dispatcher while the iterative unit is busy, so upstream is not stalled.
- Sanitizes operands on enqueue: any operand not properly NaN-boxed for its destination format is replaced by that format's canonical quiet NaN.
- Presents a registered, in-order request stream to the unit's in_valid/in_ready interface.

Parameters:
- FpFmtConfig, '1, enabled FP formats; sets Width = max_fp_width(FpFmtConfig).
- Depth, 2, number of queue entries (>=1; need not be a power of two).
- TagType, logic, opaque tag carried with each request.
- AuxType, logic, opaque aux data carried with each request.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- operands_i  in  2xWidth  operand A/B.
- is_boxed_i  in  NUM_FORMATSx2  per-format, per-operand NaN-box flags.
- rnd_mode_i  in  3  roundmode_e.
- op_i  in  4  operation_e.
- dst_fmt_i  in  3  fp_format_e.
- tag_i  in  $bits(TagType)  request tag.
- aux_i  in  $bits(AuxType)  request aux.
- in_valid_i  in  1  upstream valid.
- in_ready_o  out  1  upstream ready.
- flush_i  in  1  discard all queued requests.
- operands_o  out  2xWidth  sanitized operands.
- rnd_mode_o, op_o, dst_fmt_o, tag_o, aux_o  out  as inputs  head-entry fields.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream (div/sqrt unit) ready.
- fill_o  out  $clog2(Depth+1)  current occupancy.
- busy_o  out  1  at least one entry held.

Behaviour:
- Reset: synchronous on the rising edge of clk_i while rst_ni=0. Clears count, rd_ptr and wr_ptr to 0. Resulting outputs: out_valid_o=0, busy_o=0, fill_o=0, in_ready_o=1. Entry payloads are not reset; their outputs are don't-care while out_valid_o=0.
- push = in_valid_i & in_ready_o.
- pop = out_valid_o & out_ready_i.
- in_ready_o = (count != Depth) & ~flush_i. No pass-through when full: a pop on a full queue frees the slot only in the next cycle.
- out_valid_o = (count != 0) & ~flush_i. Head fields are driven from the rd_ptr entry and are registered (no combinational path from inputs to outputs).
- Latency: a request pushed in cycle N is visible at the outputs in cycle N+1 if the queue was empty.
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged, both pointers advance.
- Pointers increment and wrap from Depth-1 to 0.
- Ordering: strictly FIFO. Data presented at the head stays stable while out_valid_o=1 and out_ready_i=0.
- Sanitization, evaluated at push for operand k in {0,1}:
  - If is_boxed_i[dst_fmt_i][k]=0, store the canonical qNaN of dst_fmt_i, zero-extended to Width.
  - Otherwise store operands_i[k] unchanged.
  - Canonical qNaNs: FP32 0x7FC00000; FP64 0x7FF8000000000000; FP16 0x7E00; FP16ALT 0x7FC0; FP8 0x7E.
  - FP64 operands are never substituted, since FP64 is the widest format and always treated as boxed.
  - Unsupported or other formats pass through unchanged.
- Flush: while flush_i=1, in_ready_o=0 and out_valid_o=0 combinationally, and no push or pop occurs. At the next clock edge count, rd_ptr and wr_ptr become 0. flush_i overrides a simultaneous in_valid_i/out_ready_i.
- Reset asserted mid-operation: identical to flush; all entries are lost.
- fill_o = count; busy_o = (count != 0).

Test Plan:
- Reset, then a single push: FP32 DIV with A=0x3F800000, B=0x40000000, boxed=1, tag=5, out_ready_i=1. Expect out_valid_o high exactly 1 cycle after the push with identical fields; then fill_o returns 0.
- Fill: out_ready_i=0, push 3 requests with Depth=2. Expect in_ready_o=0 after 2 pushes and fill_o=2. Raise out_ready_i: expect tags 0,1 to exit in order, and in_ready_o back to 1 one cycle after the first pop.
- Unboxed operand: FP16 SQRT, is_boxed_i[FP16]=2'b01, operands_i[1]=0x1234. Expect operands_o[1]=0x7E00 and operands_o[0] unchanged.
- Simultaneous push and pop with count=1: expect fill_o stays 1 and the next head is the pushed entry; also run 5+ consecutive push/pop pairs to exercise pointer wrap with Depth=3.
- Flush with 2 entries queued and in_valid_i=1: expect out_valid_o=0 and in_ready_o=0 in the flush cycle, fill_o=0 afterwards, and the flushed-cycle input is never emitted.
- rst_ni=0 for 1 cycle with 2 entries queued: expect fill_o=0 and out_valid_o=0 the cycle after; a subsequent push with tag=9 emerges first.

Source files
------------

// File: rtl/fpnew_divsqrt_issue_queue.sv
// fpnew_divsqrt_issue_queue: in-order request FIFO in front of the iterative div/sqrt unit.
// Operands not NaN-boxed for the destination format are replaced by its canonical qNaN on enqueue.
module fpnew_divsqrt_issue_queue #(
    parameter logic [4:0]   FpFmtConfig = '1,
    parameter int unsigned  Depth       = 2,
    parameter type          TagType     = logic,
    parameter type          AuxType     = logic,
    localparam int unsigned Width = FpFmtConfig[1] ? 64 : FpFmtConfig[0] ? 32 :
                                    (FpFmtConfig[2] | FpFmtConfig[4]) ? 16 : 8,
    localparam int unsigned FillW = $clog2(Depth + 1),
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0][Width-1:0] operands_i,
    input  logic [4:0][1:0]       is_boxed_i,
    input  logic [2:0]            rnd_mode_i,
    input  logic [3:0]            op_i,
    input  logic [2:0]            dst_fmt_i,
    input  TagType                tag_i,
    input  AuxType                aux_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  flush_i,
    output logic [1:0][Width-1:0] operands_o,
    output logic [2:0]            rnd_mode_o,
    output logic [3:0]            op_o,
    output logic [2:0]            dst_fmt_o,
    output TagType                tag_o,
    output AuxType                aux_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [FillW-1:0]      fill_o,
    output logic                  busy_o
);
    // FP64 is the widest format and is never substituted, so it has no entry here.
    function automatic logic [Width-1:0] qnan(input logic [2:0] fmt);
        return fmt == 3'd0 ? Width'(64'h7FC0_0000) :
               fmt == 3'd2 ? Width'(64'h7E00) :
               fmt == 3'd3 ? Width'(64'h7E) : Width'(64'h7FC0);
    endfunction

    logic [FillW-1:0]      count;
    logic [PtrW-1:0]       rd_ptr, wr_ptr;
    logic                  push, pop, can_sub;
    logic [1:0][Width-1:0] operands_san;
    logic [1:0][Width-1:0] ops_q [Depth];
    logic [2:0]            rnd_q [Depth];
    logic [3:0]            op_q  [Depth];
    logic [2:0]            fmt_q [Depth];
    TagType                tag_q [Depth];
    AuxType                aux_q [Depth];

    assign in_ready_o  = (count != FillW'(Depth)) & ~flush_i;
    assign out_valid_o = (count != '0) & ~flush_i;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign fill_o      = count;
    assign busy_o      = count != '0;
    assign can_sub     = (dst_fmt_i == 3'd0 || dst_fmt_i == 3'd2 || dst_fmt_i == 3'd3 ||
                          dst_fmt_i == 3'd4) && FpFmtConfig[dst_fmt_i];

    always_comb begin
        for (int k = 0; k < 2; k++)
            operands_san[k] = (can_sub && !is_boxed_i[dst_fmt_i][k]) ? qnan(dst_fmt_i) : operands_i[k];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count + FillW'(push) - FillW'(pop);
            if (push)
                wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            ops_q[wr_ptr] <= operands_san;
            rnd_q[wr_ptr] <= rnd_mode_i;
            op_q[wr_ptr]  <= op_i;
            fmt_q[wr_ptr] <= dst_fmt_i;
            tag_q[wr_ptr] <= tag_i;
            aux_q[wr_ptr] <= aux_i;
        end
    end

    assign operands_o = ops_q[rd_ptr];
    assign rnd_mode_o = rnd_q[rd_ptr];
    assign op_o       = op_q[rd_ptr];
    assign dst_fmt_o  = fmt_q[rd_ptr];
    assign tag_o      = tag_q[rd_ptr];
    assign aux_o      = aux_q[rd_ptr];
endmodule

// File: tb/tb_fpnew_divsqrt_issue_queue.sv
// tb_fpnew_divsqrt_issue_queue: drives a Depth=2 and a Depth=3 queue with shared stimulus
// and compares both against queue-based reference models.
module tb_fpnew_divsqrt_issue_queue;
    localparam int W = 64;
    typedef logic [3:0] tag_t;
    typedef logic [1:0] aux_t;
    typedef struct packed {
        logic [1:0][W-1:0] ops;
        logic [2:0]        rnd;
        logic [3:0]        op;
        logic [2:0]        fmt;
        tag_t              tag;
        aux_t              aux;
    } req_t;

    logic              clk = 0, rst_ni = 0;
    logic [1:0][W-1:0] operands_i = '0;
    logic [4:0][1:0]   is_boxed_i = '1;
    logic [2:0]        rnd_mode_i = '0, dst_fmt_i = '0;
    logic [3:0]        op_i = '0;
    tag_t              tag_i = '0;
    aux_t              aux_i = '0;
    logic              in_valid_i = 0, out_ready_i = 0, flush_i = 0;

    logic [1:0][W-1:0] ops_o [2];
    logic [2:0]        rnd_o [2], fmt_o [2];
    logic [3:0]        op_o [2];
    tag_t              tag_o [2];
    aux_t              aux_o [2];
    logic              in_ready_o [2], out_valid_o [2], busy_o [2];
    logic [1:0]        fill_o [2];
    req_t              head [2];

    req_t mq [2][$];
    int   n_checks = 0, n_errors = 0;
    bit   known = 0;

    always #5 clk = ~clk;

    fpnew_divsqrt_issue_queue #(.Depth(2), .TagType(tag_t), .AuxType(aux_t)) u_d2 (
        .clk_i(clk), .rst_ni(rst_ni), .operands_i(operands_i), .is_boxed_i(is_boxed_i),
        .rnd_mode_i(rnd_mode_i), .op_i(op_i), .dst_fmt_i(dst_fmt_i), .tag_i(tag_i), .aux_i(aux_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o[0]), .flush_i(flush_i),
        .operands_o(ops_o[0]), .rnd_mode_o(rnd_o[0]), .op_o(op_o[0]), .dst_fmt_o(fmt_o[0]),
        .tag_o(tag_o[0]), .aux_o(aux_o[0]), .out_valid_o(out_valid_o[0]),
        .out_ready_i(out_ready_i), .fill_o(fill_o[0]), .busy_o(busy_o[0]));

    fpnew_divsqrt_issue_queue #(.Depth(3), .TagType(tag_t), .AuxType(aux_t)) u_d3 (
        .clk_i(clk), .rst_ni(rst_ni), .operands_i(operands_i), .is_boxed_i(is_boxed_i),
        .rnd_mode_i(rnd_mode_i), .op_i(op_i), .dst_fmt_i(dst_fmt_i), .tag_i(tag_i), .aux_i(aux_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o[1]), .flush_i(flush_i),
        .operands_o(ops_o[1]), .rnd_mode_o(rnd_o[1]), .op_o(op_o[1]), .dst_fmt_o(fmt_o[1]),
        .tag_o(tag_o[1]), .aux_o(aux_o[1]), .out_valid_o(out_valid_o[1]),
        .out_ready_i(out_ready_i), .fill_o(fill_o[1]), .busy_o(busy_o[1]));

    assign head[0] = {ops_o[0], rnd_o[0], op_o[0], fmt_o[0], tag_o[0], aux_o[0]};
    assign head[1] = {ops_o[1], rnd_o[1], op_o[1], fmt_o[1], tag_o[1], aux_o[1]};

    task automatic check(input string t, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", t, got, exp);
        end
    endtask

    function automatic logic [W-1:0] qnan_of(input logic [2:0] f);
        case (f)
            3'd0:    return 64'h7FC0_0000;
            3'd2:    return 64'h7E00;
            3'd3:    return 64'h7E;
            default: return 64'h7FC0;
        endcase
    endfunction

    // Expected stored request: unboxed FP32/FP16/FP8/FP16ALT operands become that format's qNaN.
    function automatic req_t cur_req();
        req_t r;
        for (int k = 0; k < 2; k++)
            r.ops[k] = (dst_fmt_i inside {3'd0, 3'd2, 3'd3, 3'd4} && !is_boxed_i[dst_fmt_i][k])
                       ? qnan_of(dst_fmt_i) : operands_i[k];
        r.rnd = rnd_mode_i;
        r.op  = op_i;
        r.fmt = dst_fmt_i;
        r.tag = tag_i;
        r.aux = aux_i;
        return r;
    endfunction

    task automatic cyc(input logic v, input logic r, input logic f, input logic rs);
        bit   psh [2], pp [2];
        req_t e;
        in_valid_i  = v;
        out_ready_i = r;
        flush_i     = f;
        rst_ni      = rs;
        #1;
        e = cur_req();
        for (int d = 0; d < 2; d++) begin
            int n   = mq[d].size();
            bit er  = (n != d + 2) && !f;
            bit ev  = (n != 0) && !f;
            if (known) begin
                check($sformatf("in_ready%0d", d), in_ready_o[d], er);
                check($sformatf("out_valid%0d", d), out_valid_o[d], ev);
                check($sformatf("fill%0d", d), fill_o[d], n);
                check($sformatf("busy%0d", d), busy_o[d], n != 0);
                if (ev) check($sformatf("head%0d", d), head[d], mq[d][0]);
            end
            psh[d] = v && er;
            pp[d]  = ev && r;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rs || f) mq[d].delete();
            else begin
                if (pp[d]) void'(mq[d].pop_front());
                if (psh[d]) mq[d].push_back(e);
            end
        end
        if (!rs) known = 1;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1);
    endtask

    initial begin
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        check("reset_ready", in_ready_o[0], 1);
        // single FP32 DIV push
        dst_fmt_i = 3'd0; op_i = 4'd4; tag_i = 4'd5;
        operands_i[0] = 64'h3F80_0000; operands_i[1] = 64'h4000_0000;
        cyc(1, 1, 0, 1);
        check("t1_valid", out_valid_o[0], 1);
        check("t1_tag", tag_o[0], 4'd5);
        check("t1_opb", ops_o[0][1], 64'h4000_0000);
        cyc(0, 1, 0, 1);
        check("t1_empty", fill_o[0], 0);
        // fill Depth=2
        for (int i = 0; i < 3; i++) begin tag_i = 4'(i); cyc(1, 0, 0, 1); end
        check("full_ready", in_ready_o[0], 0);
        check("full_fill", fill_o[0], 2);
        check("full_head", tag_o[0], 4'd0);
        cyc(0, 1, 0, 1);
        check("pop_ready", in_ready_o[0], 1);
        check("pop_head", tag_o[0], 4'd1);
        drain();
        // unboxed FP16 operand B
        dst_fmt_i = 3'd2; op_i = 4'd5; is_boxed_i = '1; is_boxed_i[2] = 2'b01;
        operands_i[0] = 64'hFFFF_FFFF_FFFF_3C00; operands_i[1] = 64'h1234; tag_i = 4'd7;
        cyc(1, 0, 0, 1);
        check("unbox_b", ops_o[0][1], 64'h7E00);
        check("unbox_a", ops_o[0][0], 64'hFFFF_FFFF_FFFF_3C00);
        drain();
        is_boxed_i = '1;
        // simultaneous push/pop at count=1, then wrap
        tag_i = 4'd1; cyc(1, 0, 0, 1);
        tag_i = 4'd2; cyc(1, 1, 0, 1);
        check("pp_fill", fill_o[0], 1);
        check("pp_head", tag_o[0], 4'd2);
        for (int i = 0; i < 7; i++) begin tag_i = 4'(i + 3); cyc(1, 1, 0, 1); end
        drain();
        // flush with two queued and a request offered
        tag_i = 4'd3; cyc(1, 0, 0, 1);
        tag_i = 4'd4; cyc(1, 0, 0, 1);
        tag_i = 4'hE; cyc(1, 1, 1, 1);
        check("flush_fill", fill_o[1], 0);
        tag_i = 4'd6; cyc(1, 0, 0, 1);
        check("post_flush_head", tag_o[1], 4'd6);
        drain();
        // reset mid-operation
        tag_i = 4'd1; cyc(1, 0, 0, 1);
        tag_i = 4'd2; cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 0);
        check("rst_fill", fill_o[0], 0);
        check("rst_valid", out_valid_o[0], 0);
        tag_i = 4'd9; cyc(1, 0, 0, 1);
        check("rst_head", tag_o[0], 4'd9);
        drain();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            operands_i = {$urandom, $urandom, $urandom, $urandom};
            is_boxed_i = 10'($urandom);
            dst_fmt_i  = 3'($urandom);
            rnd_mode_i = 3'($urandom);
            op_i       = 4'($urandom);
            tag_i      = 4'($urandom);
            aux_i      = 2'($urandom);
            cyc(1'($urandom), 1'($urandom), $urandom_range(0, 29) == 0, $urandom_range(0, 99) != 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
